// File: rtl/ram_fifo_wxd.sv
// ram_fifo_wxd: first-word-fall-through FIFO on a distributed RAM.
// Level-based status flags, sticky overflow/underflow error flags.
module ram_fifo_wxd #(
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_DEPTH   = 4,
    parameter int AFULL_LEVEL  = (1 << DATA_DEPTH) - 2,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_DEPTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic                  ovfl,
    output logic                  unfl,
    input  logic                  clr_err
);

    localparam int N = 1 << DATA_DEPTH;
    localparam logic [DATA_DEPTH:0] LVL_FULL = (DATA_DEPTH+1)'(N);
    localparam logic [DATA_DEPTH:0] LVL_AF   = (DATA_DEPTH+1)'(AFULL_LEVEL);
    localparam logic [DATA_DEPTH:0] LVL_AE   = (DATA_DEPTH+1)'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem [N];

    logic [DATA_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DATA_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_DEPTH:0]   level_q, level_d;
    logic                  ovfl_q, ovfl_d;
    logic                  unfl_q, unfl_d;
    logic                  rd_ok, wr_ok;

    // Flags come only from the registered level, never from pointers.
    assign empty  = (level_q == '0);
    assign full   = (level_q == LVL_FULL);
    assign afull  = (level_q >= LVL_AF);
    assign aempty = (level_q <= LVL_AE);
    assign level  = level_q;
    assign ovfl   = ovfl_q;
    assign unfl   = unfl_q;

    // Asynchronous read port: head word falls through.
    assign dout = mem[rd_ptr_q];

    // A pop frees a slot, so a full FIFO may take a write on the same edge.
    assign rd_ok = re & ~empty;
    assign wr_ok = we & (~full | rd_ok);

    // Next-state for pointers, level and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + DATA_DEPTH'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + DATA_DEPTH'(1);
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // A new error event beats a simultaneous clear.
        ovfl_d = (we & ~wr_ok) | (ovfl_q & ~clr_err);
        unfl_d = (re & empty)  | (unfl_q & ~clr_err);
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovfl_q   <= 1'b0;
            unfl_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovfl_q   <= ovfl_d;
            unfl_q   <= unfl_d;
        end
    end

    // RAM write port; contents are not reset, writes blocked during reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: tb/tb_ram_fifo_wxd.sv
// tb_ram_fifo_wxd: randomized and directed checks of ram_fifo_wxd
// against a queue-based reference model.
module tb_ram_fifo_wxd;

    localparam int DW = 16;
    localparam int DD = 4;
    localparam int N  = 1 << DD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0, re = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic [DD:0]   level;
    logic          full, empty, afull, aempty, ovfl, unfl;
    logic [5:0]    st;

    int errs   = 0;
    int checks = 0;

    logic [DW-1:0] q[$];
    logic          m_ovfl = 1'b0;
    logic          m_unfl = 1'b0;

    ram_fifo_wxd #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
        .clk(clk), .rst(rst), .we(we), .din(din), .re(re),
        .dout(dout), .level(level), .full(full), .empty(empty),
        .afull(afull), .aempty(aempty), .ovfl(ovfl), .unfl(unfl),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    assign st = {full, empty, afull, aempty, ovfl, unfl};

    function automatic logic [5:0] exp_st();
        int s = q.size();
        return {s == N, s == 0, s >= N - 2, s <= 2, m_ovfl, m_unfl};
    endfunction

    // One clock: apply inputs, clock the DUT, advance the model, settle.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d,
                         input logic c, input logic rs);
        bit is_empty, is_full, rd, wr;
        we = w; re = r; din = d; clr_err = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovfl = 1'b0;
            m_unfl = 1'b0;
        end else begin
            is_empty = (q.size() == 0);
            is_full  = (q.size() == N);
            rd = r && !is_empty;
            wr = w && (!is_full || rd);
            m_ovfl = (w && !wr) || (m_ovfl && !c);
            m_unfl = (r && is_empty) || (m_unfl && !c);
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(d);
        end
        #1;
        we = 1'b0; re = 1'b0; clr_err = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1);
        checks++;
        if (level !== '0) begin
            errs++;
            $display("FAIL reset_level: got %0d exp 0", level);
        end
        checks++;
        if (st !== 6'b010100) begin
            errs++;
            $display("FAIL reset_flags: got %b exp 010100", st);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= N; i++) begin
            cycle(1'b1, 1'b0, DW'(i), 1'b0, 1'b0);
            checks++;
            if (level !== (DD+1)'(q.size()) || st !== exp_st()) begin
                errs++;
                $display("FAIL fill_%0d: got lvl=%0d st=%b exp lvl=%0d st=%b",
                         i, level, st, q.size(), exp_st());
            end
        end
        checks++;
        if (dout !== 16'h0001 || full !== 1'b1 || level !== 5'd16) begin
            errs++;
            $display("FAIL fill_end: got dout=%h full=%b lvl=%0d exp 0001 1 16",
                     dout, full, level);
        end
    endtask

    task automatic test_overflow_drain();
        cycle(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0);
        checks++;
        if (ovfl !== 1'b1 || level !== 5'd16) begin
            errs++;
            $display("FAIL ovfl_set: got ovfl=%b lvl=%0d exp 1 16", ovfl, level);
        end
        for (int i = 1; i <= N; i++) begin
            checks++;
            if (dout !== DW'(i)) begin
                errs++;
                $display("FAIL drain_data_%0d: got %h exp %h", i, dout, DW'(i));
            end
            cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
            checks++;
            if (level !== (DD+1)'(q.size()) || st !== exp_st()) begin
                errs++;
                $display("FAIL drain_st_%0d: got lvl=%0d st=%b exp lvl=%0d st=%b",
                         i, level, st, q.size(), exp_st());
            end
        end
        checks++;
        if (empty !== 1'b1 || aempty !== 1'b1) begin
            errs++;
            $display("FAIL drain_end: got empty=%b aempty=%b exp 1 1", empty, aempty);
        end
    endtask

    task automatic test_underflow_simul();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (ovfl !== 1'b0) begin
            errs++;
            $display("FAIL clr_ovfl: got %b exp 0", ovfl);
        end
        cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        checks++;
        if (unfl !== 1'b1 || level !== 5'd1 || dout !== 16'h1234) begin
            errs++;
            $display("FAIL empty_wr_rd: got unfl=%b lvl=%0d dout=%h exp 1 1 1234",
                     unfl, level, dout);
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (unfl !== 1'b0 || level !== 5'd1) begin
            errs++;
            $display("FAIL clr_unfl: got unfl=%b lvl=%0d exp 0 1", unfl, level);
        end
        // Error event in the same cycle as clear must win.
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, '0, 1'b1, 1'b0);
        checks++;
        if (unfl !== 1'b1) begin
            errs++;
            $display("FAIL clr_vs_event: got unfl=%b exp 1", unfl);
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_full_simul();
        logic [DW-1:0] d = 16'h0100;
        while (q.size() < N) begin
            cycle(1'b1, 1'b0, d, 1'b0, 1'b0);
            d++;
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (dout !== q[0]) begin
                errs++;
                $display("FAIL full_rw_data_%0d: got %h exp %h", i, dout, q[0]);
            end
            cycle(1'b1, 1'b1, d, 1'b0, 1'b0);
            d++;
            checks++;
            if (level !== 5'd16 || ovfl !== 1'b0 || st !== exp_st()) begin
                errs++;
                $display("FAIL full_rw_st_%0d: got lvl=%0d st=%b exp 16 %b",
                         i, level, st, exp_st());
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, DW'(i + 16'h40), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b1);
        checks++;
        if (level !== '0 || st !== 6'b010100) begin
            errs++;
            $display("FAIL mid_reset: got lvl=%0d st=%b exp 0 010100", level, st);
        end
        cycle(1'b1, 1'b0, 16'h00AA, 1'b0, 1'b0);
        checks++;
        if (dout !== 16'h00AA || level !== 5'd1) begin
            errs++;
            $display("FAIL mid_reset_wr: got dout=%h lvl=%0d exp 00aa 1", dout, level);
        end
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        checks++;
        if (empty !== 1'b1) begin
            errs++;
            $display("FAIL mid_reset_rd: got empty=%b exp 1", empty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic w, r, c, rs;
            int bias = (i / 100) % 3;
            w  = ($urandom_range(0, 9) < 3 + 2 * bias);
            r  = ($urandom_range(0, 9) < 7 - 2 * bias);
            c  = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 199) == 0);
            cycle(w, r, DW'($urandom), c, rs);
            checks++;
            if (level !== (DD+1)'(q.size()) || st !== exp_st()) begin
                errs++;
                $display("FAIL rand_st_%0d: got lvl=%0d st=%b exp lvl=%0d st=%b",
                         i, level, st, q.size(), exp_st());
            end
            if (q.size() != 0) begin
                checks++;
                if (dout !== q[0]) begin
                    errs++;
                    $display("FAIL rand_dout_%0d: got %h exp %h", i, dout, q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow_simul();
        test_full_simul();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ram_fifo_wxd.md
RAM_FIFO_WXD -- requirements
Module: ram_fifo_wxd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter DATA_DEPTH, default 4, log2 of entry count (capacity N = 2^DATA_DEPTH).
REQ-003 SHALL have parameter AFULL_LEVEL, default N-2, almost-full threshold in words.
REQ-004 SHALL have parameter AEMPTY_LEVEL, default 2, almost-empty threshold in words.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port we  input  1  write request.
REQ-008 SHALL have port din  input  DATA_WIDTH  write data.
REQ-009 SHALL have port re  input  1  read request (pop head word).
REQ-010 SHALL have port dout  output  DATA_WIDTH  current head word (first-word-fall-through).
REQ-011 SHALL have port level  output  DATA_DEPTH+1  words stored, 0..N.
REQ-012 SHALL have ports full, empty, afull, aempty  output  1 each  status flags.
REQ-013 SHALL have ports ovfl, unfl  output  1 each  sticky overflow / underflow errors.
REQ-014 SHALL have port clr_err  input  1  clears ovfl and unfl.

Function
REQ-015 SHALL store data in an N x DATA_WIDTH distributed RAM, write port at wr_ptr, asynchronous read port at rd_ptr; RAM contents not reset.
REQ-016 SHALL drive dout = ram[rd_ptr] combinationally; dout value is don't-care while empty=1.
REQ-017 SHALL accept a read (rd_ok) when re=1 and empty=0; rd_ptr increments mod N on the same edge.
REQ-018 SHALL accept a write (wr_ok) when we=1 and (full=0 or rd_ok=1); din written at wr_ptr, wr_ptr increments mod N.
REQ-019 SHALL update level: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
REQ-020 SHALL wrap pointers from N-1 to 0 with no gap; full/empty derive from level, not pointer compare.
REQ-021 SHALL derive empty=(level==0), full=(level==N), afull=(level>=AFULL_LEVEL), aempty=(level<=AEMPTY_LEVEL), all from registered level (valid the cycle after the accepting edge).
REQ-022 SHALL, when empty and we=re=1, accept the write, ignore the read, set unfl; next cycle level=1, dout=din.
REQ-023 SHALL, when full and we=re=1, accept both; level stays N, no ovfl.
REQ-024 SHALL set ovfl on any edge with we=1 and wr_ok=0; rejected data discarded, state unchanged.
REQ-025 SHALL set unfl on any edge with re=1 and empty=1.
REQ-026 SHALL clear ovfl/unfl on clr_err=1, except an error event in the same cycle wins (flag set).
REQ-027 SHALL have zero write-to-read latency: word written on edge k visible on dout after edge k when it becomes head.

Reset
REQ-028 SHALL, on rst=1 at a rising edge, set wr_ptr=0, rd_ptr=0, level=0, ovfl=0, unfl=0; hence empty=1, full=0, afull=0, aempty=1.
REQ-029 SHALL give rst priority over we, re, clr_err, including mid-operation with partial fill; RAM writes during reset cycle SHALL be suppressed.

Verification
REQ-030 SHALL cover: reset, write 0x0001..0x0010 (16 words, defaults) -> level 16, full=1, afull=1 from level 14, dout=0x0001.
REQ-031 SHALL cover: from full, we=1 re=0 with 0xDEAD -> ovfl=1, level 16; then 16 reads -> data 0x0001..0x0010 in order, empty=1, aempty=1 from level 2.
REQ-032 SHALL cover: empty, we=re=1 din=0x1234 -> unfl=1, level=1, dout=0x1234 next cycle; clr_err -> unfl=0.
REQ-033 SHALL cover: full, we=re=1 for 40 cycles with incrementing data -> level stays 16, pointers wrap, output order preserved, ovfl=0.
REQ-034 SHALL cover: rst asserted at level 7 with we=re=1 -> next cycle level=0, empty=1, flags cleared, subsequent write 0x00AA read back as 0x00AA.
